// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard and forwarding scoreboard for a 5-stage pipeline.
// Tracks EX/MEM/WB destinations, raises load-use stalls/bubbles, and registers EX forwarding selects.
module id_hazard_scoreboard #(
  parameter int unsigned CNT_W     = 32,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_insn_vld,
  input  logic             i_id_is_rs1,
  input  logic             i_id_is_rs2,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic [4:0]       i_id_rd_addr,
  input  logic             i_id_rd_wren,
  input  logic             i_id_mem_rden,
  input  logic             i_ex_flush,
  input  logic             i_perf_clr,
  output logic             o_stall,
  output logic             o_id_bubble,
  output logic [1:0]       o_ex_fwd_a_sel,
  output logic [1:0]       o_ex_fwd_b_sel,
  output logic [31:0]      o_busy_mask,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_bubble_cnt
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned NREG   = 32;

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] rd;
    logic             ld;
  } slot_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2,
    FWD_BYP = 2'd3
  } fwd_sel_e;

  slot_t      s_ex, s_mem, s_wb, s_ex_nxt;
  fwd_sel_e   fwd_a_q, fwd_b_q, fwd_a_nxt, fwd_b_nxt;
  logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

  logic rs1_hit_ex, rs1_hit_mem, rs1_hit_wb;
  logic rs2_hit_ex, rs2_hit_mem, rs2_hit_wb;
  logic load_use, issue;

  function automatic logic rs_hit(input slot_t s, input logic rd_en, input logic [REG_W-1:0] addr);
    return s.vld && rd_en && (addr == s.rd) && (addr != '0);
  endfunction

  // Youngest producer wins; an EX-slot producer will be in MEM when the consumer reaches EX.
  function automatic fwd_sel_e pick_fwd(input logic h_ex, input logic h_mem, input logic h_wb);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (h_ex)
      sel = FWD_MEM;
    else if (h_mem)
      sel = FWD_WB;
    else if (h_wb && WB_BYPASS)
      sel = FWD_BYP;
    return sel;
  endfunction

  function automatic logic [NREG-1:0] slot_onehot(input slot_t s);
    return s.vld ? (NREG'(1) << s.rd) : '0;
  endfunction

  assign rs1_hit_ex  = rs_hit(s_ex,  i_id_is_rs1, i_id_rs1_addr);
  assign rs1_hit_mem = rs_hit(s_mem, i_id_is_rs1, i_id_rs1_addr);
  assign rs1_hit_wb  = rs_hit(s_wb,  i_id_is_rs1, i_id_rs1_addr);
  assign rs2_hit_ex  = rs_hit(s_ex,  i_id_is_rs2, i_id_rs2_addr);
  assign rs2_hit_mem = rs_hit(s_mem, i_id_is_rs2, i_id_rs2_addr);
  assign rs2_hit_wb  = rs_hit(s_wb,  i_id_is_rs2, i_id_rs2_addr);

  // A flush kills the ID instruction, so it never stalls while a redirect is in flight.
  assign load_use    = i_id_insn_vld & s_ex.ld & (rs1_hit_ex | rs2_hit_ex);
  assign o_stall     = load_use & ~i_ex_flush;
  assign o_id_bubble = o_stall | i_ex_flush;
  assign issue       = i_id_insn_vld & ~o_id_bubble;

  always_comb begin
    s_ex_nxt  = '0;
    fwd_a_nxt = FWD_RF;
    fwd_b_nxt = FWD_RF;
    if (issue) begin
      s_ex_nxt.vld = i_id_rd_wren & (i_id_rd_addr != '0);
      s_ex_nxt.rd  = i_id_rd_addr;
      s_ex_nxt.ld  = i_id_mem_rden;
      fwd_a_nxt    = pick_fwd(rs1_hit_ex, rs1_hit_mem, rs1_hit_wb);
      fwd_b_nxt    = pick_fwd(rs2_hit_ex, rs2_hit_mem, rs2_hit_wb);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s_ex         <= '0;
      s_mem        <= '0;
      s_wb         <= '0;
      fwd_a_q      <= FWD_RF;
      fwd_b_q      <= FWD_RF;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      s_wb    <= s_mem;
      s_mem   <= s_ex;
      s_ex    <= s_ex_nxt;
      fwd_a_q <= fwd_a_nxt;
      fwd_b_q <= fwd_b_nxt;
      if (i_perf_clr)
        stall_cnt_q <= '0;
      else if (o_stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (i_perf_clr)
        bubble_cnt_q <= '0;
      else if (o_id_bubble && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign o_ex_fwd_a_sel = fwd_a_q;
  assign o_ex_fwd_b_sel = fwd_b_q;
  assign o_busy_mask    = (slot_onehot(s_ex) | slot_onehot(s_mem) | slot_onehot(s_wb)) & ~NREG'(1);
  assign o_stall_cnt    = stall_cnt_q;
  assign o_bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_id_hazard_scoreboard;

  localparam int K_STALL = 0, K_BUB = 1, K_FA = 2, K_FB = 3, K_MASK = 4, K_SCNT = 5, K_BCNT = 6;
  localparam int K_FA2 = 7, K_SCNT2 = 8, K_FB2 = 9, K_BCNT2 = 10, K_STALL2 = 11, K_BUB2 = 12, K_MASK2 = 13;

  logic clk = 1'b0;
  logic rst, vld, r1e, r2e, wr, ld, flush, clr;
  logic [4:0] r1, r2, rd;

  logic stall, bubble, stall2, bubble2;
  logic [1:0] fa, fb, fa2, fb2;
  logic [31:0] mask, mask2;
  logic [3:0] scnt, bcnt;
  logic [31:0] scnt2, bcnt2;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  id_hazard_scoreboard #(.CNT_W(4), .WB_BYPASS(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_insn_vld(vld), .i_id_is_rs1(r1e), .i_id_is_rs2(r2e),
    .i_id_rs1_addr(r1), .i_id_rs2_addr(r2), .i_id_rd_addr(rd), .i_id_rd_wren(wr),
    .i_id_mem_rden(ld), .i_ex_flush(flush), .i_perf_clr(clr), .o_stall(stall),
    .o_id_bubble(bubble), .o_ex_fwd_a_sel(fa), .o_ex_fwd_b_sel(fb), .o_busy_mask(mask),
    .o_stall_cnt(scnt), .o_bubble_cnt(bcnt)
  );

  id_hazard_scoreboard #(.CNT_W(32), .WB_BYPASS(1'b0)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_id_insn_vld(vld), .i_id_is_rs1(r1e), .i_id_is_rs2(r2e),
    .i_id_rs1_addr(r1), .i_id_rs2_addr(r2), .i_id_rd_addr(rd), .i_id_rd_wren(wr),
    .i_id_mem_rden(ld), .i_ex_flush(flush), .i_perf_clr(clr), .o_stall(stall2),
    .o_id_bubble(bubble2), .o_ex_fwd_a_sel(fa2), .o_ex_fwd_b_sel(fb2), .o_busy_mask(mask2),
    .o_stall_cnt(scnt2), .o_bubble_cnt(bcnt2)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int k);
    case (k)
      K_STALL:  return 32'(stall);
      K_BUB:    return 32'(bubble);
      K_FA:     return 32'(fa);
      K_FB:     return 32'(fb);
      K_MASK:   return mask;
      K_SCNT:   return 32'(scnt);
      K_BCNT:   return 32'(bcnt);
      K_FA2:    return 32'(fa2);
      K_SCNT2:  return scnt2;
      K_FB2:    return 32'(fb2);
      K_BCNT2:  return bcnt2;
      K_STALL2: return 32'(stall2);
      K_BUB2:   return 32'(bubble2);
      K_MASK2:  return mask2;
      default:  return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: every entry due this cycle (or overdue) is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      act = sample(e.kind);
      n_cmp++;
      if (e.cyc != cyc || act !== e.val) begin
        n_bad++;
        $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d, due %0d)", e.nm, act, e.val, cyc, e.cyc);
      end
    end
  end

  task automatic ex(input int kind, input int dc, input logic [31:0] val, input string nm);
    exp_t e;
    e.cyc = cyc + dc;
    e.kind = kind;
    e.val = val;
    e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic e1, input logic [4:0] a1, input logic e2,
                       input logic [4:0] a2, input logic [4:0] d, input logic w, input logic l);
    @(posedge clk);
    #1;
    vld = v; r1e = e1; r1 = a1; r2e = e2; r2 = a2; rd = d; wr = w; ld = l;
    flush = 1'b0;
    clr = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (3) idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; vld = 1'b0; r1e = 1'b0; r2e = 1'b0; r1 = '0; r2 = '0; rd = '0;
    wr = 1'b0; ld = 1'b0; flush = 1'b0; clr = 1'b0;

    // Reset with flush active: bubble follows the flush, nothing is counted.
    idle(); flush = 1'b1;
    ex(K_STALL, 0, 0, "rst_flush_stall");
    ex(K_BUB,   0, 1, "rst_flush_bubble");
    #1;
    n_cmp++;
    if (bubble !== 1'b1 || stall !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_flush_direct: stall=%b bubble=%b", stall, bubble);
    end
    idle();
    ex(K_STALL, 0, 0, "rst_stall");
    ex(K_BUB,   0, 0, "rst_bubble");
    ex(K_MASK,  0, 0, "rst_mask");
    ex(K_FA,    0, 0, "rst_fwd_a");
    ex(K_FB,    0, 0, "rst_fwd_b");
    ex(K_SCNT,  0, 0, "rst_stall_cnt");
    ex(K_BCNT,  0, 0, "rst_bubble_cnt");
    idle(); rst = 1'b1;

    // 1: add x5 ; add x7,x5,x5
    drive(1, 1, 5'd1, 1, 5'd2, 5'd5, 1, 0);
    ex(K_STALL, 0, 0, "t1_prod_stall");
    drive(1, 1, 5'd5, 1, 5'd5, 5'd7, 1, 0);
    ex(K_STALL, 0, 0, "t1_cons_stall");
    ex(K_BUB,   0, 0, "t1_cons_bubble");
    ex(K_MASK,  0, 32'h0000_0020, "t1_mask");
    ex(K_FA,    1, 1, "t1_fwd_a");
    ex(K_FB,    1, 1, "t1_fwd_b");
    #1;
    n_cmp++;
    if (stall !== 1'b0 || bubble !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_direct: stall=%b bubble=%b", stall, bubble);
    end
    idle();
    ex(K_MASK,  0, 32'h0000_00a0, "t1_mask2");
    drain();

    // 2: lw x6 ; add x8,x6,x1
    drive(1, 1, 5'd1, 0, 5'd0, 5'd6, 1, 1);
    drive(1, 1, 5'd6, 1, 5'd1, 5'd8, 1, 0);
    ex(K_STALL, 0, 1, "t2_stall");
    ex(K_BUB,   0, 1, "t2_bubble");
    ex(K_FA,    1, 0, "t2_bubble_fwd_a");
    #1;
    n_cmp++;
    if (stall !== 1'b1 || bubble !== 1'b1) begin
      n_bad++;
      $display("FAIL t2_direct: stall=%b bubble=%b", stall, bubble);
    end
    drive(1, 1, 5'd6, 1, 5'd1, 5'd8, 1, 0);
    ex(K_STALL, 0, 0, "t2_issue_stall");
    ex(K_BUB,   0, 0, "t2_issue_bubble");
    ex(K_SCNT,  0, 1, "t2_stall_cnt");
    ex(K_BCNT,  0, 1, "t2_bubble_cnt");
    ex(K_SCNT2, 0, 1, "t2_stall_cnt_w32");
    ex(K_FA,    1, 2, "t2_fwd_a");
    ex(K_FB,    1, 0, "t2_fwd_b");
    idle();
    drain();

    // 3: x0 producer and x0 consumer
    drive(1, 1, 5'd1, 1, 5'd2, 5'd0, 1, 0);
    drive(1, 1, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    ex(K_STALL, 0, 0, "t3_stall");
    ex(K_MASK,  0, 0, "t3_mask");
    ex(K_FA,    1, 0, "t3_fwd_a");
    ex(K_FB,    1, 0, "t3_fwd_b");
    idle();
    ex(K_MASK,  0, 0, "t3_mask2");

    // 4: load-use coinciding with a flush
    drive(1, 1, 5'd1, 0, 5'd0, 5'd6, 1, 1);
    drive(1, 1, 5'd6, 1, 5'd1, 5'd8, 1, 0); flush = 1'b1;
    ex(K_STALL, 0, 0, "t4_stall");
    ex(K_BUB,   0, 1, "t4_bubble");
    ex(K_STALL2, 0, 0, "t4_stall_w32");
    ex(K_BUB2,  0, 1, "t4_bubble_w32");
    ex(K_FA,    1, 0, "t4_fwd_a");
    #1;
    n_cmp++;
    if (stall !== 1'b0 || bubble !== 1'b1 || stall2 !== 1'b0 || bubble2 !== 1'b1) begin
      n_bad++;
      $display("FAIL t4_direct: stall=%b bubble=%b stall2=%b bubble2=%b", stall, bubble, stall2, bubble2);
    end
    idle();
    ex(K_MASK,  0, 32'h0000_0040, "t4_mask");
    ex(K_SCNT,  0, 1, "t4_stall_cnt");
    ex(K_BCNT,  0, 2, "t4_bubble_cnt");
    ex(K_BCNT2, 0, 2, "t4_bubble_cnt_w32");
    drain();

    // 5: x1,x2,x3 in flight, consumer reads x1 and x3, then reset mid-sequence
    drive(1, 0, 5'd0, 0, 5'd0, 5'd1, 1, 0);
    drive(1, 0, 5'd0, 0, 5'd0, 5'd2, 1, 0);
    drive(1, 0, 5'd0, 0, 5'd0, 5'd3, 1, 0);
    drive(1, 1, 5'd1, 1, 5'd3, 5'd0, 0, 0);
    ex(K_STALL, 0, 0, "t5_stall");
    ex(K_MASK,  0, 32'h0000_000e, "t5_mask");
    ex(K_MASK2, 0, 32'h0000_000e, "t5_mask_w32");
    ex(K_FA,    1, 3, "t5_fwd_a_bypass");
    ex(K_FB,    1, 1, "t5_fwd_b");
    ex(K_FA2,   1, 0, "t5_fwd_a_nobypass");
    ex(K_FB2,   1, 1, "t5_fwd_b_nobypass");
    drive(1, 1, 5'd1, 1, 5'd3, 5'd0, 0, 0); rst = 1'b0;
    ex(K_MASK,  1, 0, "t5_rst_mask");
    ex(K_FA,    1, 0, "t5_rst_fwd_a");
    ex(K_FB,    1, 0, "t5_rst_fwd_b");
    ex(K_SCNT,  1, 0, "t5_rst_stall_cnt");
    ex(K_BCNT,  1, 0, "t5_rst_bubble_cnt");
    ex(K_SCNT2, 1, 0, "t5_rst_stall_cnt_w32");
    idle(); rst = 1'b1;

    // 6: 20 load-use pairs saturate the 4-bit counters
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 5'd0, 0, 5'd0, 5'd6, 1, 1);
      drive(1, 1, 5'd6, 0, 5'd0, 5'd0, 0, 0);
      ex(K_STALL, 0, 1, "t6_stall");
      drive(1, 1, 5'd6, 0, 5'd0, 5'd0, 0, 0);
    end
    idle();
    ex(K_SCNT,  0, 15, "t6_stall_cnt_sat");
    ex(K_BCNT,  0, 15, "t6_bubble_cnt_sat");
    ex(K_SCNT2, 0, 20, "t6_stall_cnt_w32");
    ex(K_BCNT2, 0, 20, "t6_bubble_cnt_w32");
    drive(1, 0, 5'd0, 0, 5'd0, 5'd6, 1, 1);
    drive(1, 1, 5'd6, 0, 5'd0, 5'd0, 0, 0); clr = 1'b1;
    ex(K_STALL, 0, 1, "t6_clr_stall");
    ex(K_SCNT,  1, 0, "t6_clr_stall_cnt");
    ex(K_BCNT,  1, 0, "t6_clr_bubble_cnt");
    ex(K_SCNT2, 1, 0, "t6_clr_stall_cnt_w32");
    drive(1, 1, 5'd6, 0, 5'd0, 5'd0, 0, 0);
    idle();

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (scnt !== 4'd0 || bcnt !== 4'd0) begin
      n_bad++;
      $display("FAIL t6_final_direct: stall_cnt=%0d bubble_cnt=%0d", scnt, bcnt);
    end
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never compared, expected 'h%0h at cycle %0d", e.nm, e.val, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
